// File: rtl/gsram_16384x1_arb_pkg.sv
// Shared types and constants for the GSRAM_16384x1 requester arbiter.
package gsram_16384x1_arb_pkg;

    localparam int unsigned ABITS_DEF = 14;
    localparam int unsigned RD_LAT    = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Per-port SRAM control bits (address carried separately, width is parametric)
    typedef struct packed {
        logic ce;
        logic we;
        logic d;
    } port_ctl_t;

endpackage

// File: rtl/gsram_16384x1_arb_if.sv
// Requester-side bus: per-requester request/grant handshake and read response.
interface gsram_16384x1_arb_if
    import gsram_16384x1_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned ABITS = ABITS_DEF
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_we;
    logic [NREQ*ABITS-1:0] req_addr;
    logic [NREQ-1:0]       req_wdata;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/gsram_rr_pick.sv
// Rotating-priority picker: up to two grants per cycle, second grant skips
// any candidate that hits the first grant's address when either side writes.
module gsram_rr_pick #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned ABITS = 14,
    parameter int unsigned IW    = 2
) (
    input  logic [NREQ-1:0]       valid_i,
    input  logic [NREQ-1:0]       we_i,
    input  logic [NREQ*ABITS-1:0] addr_i,
    input  logic [IW-1:0]         ptr_i,
    output logic                  g0_vld_o,
    output logic [IW-1:0]         g0_idx_o,
    output logic                  g1_vld_o,
    output logic [IW-1:0]         g1_idx_o,
    output logic [NREQ-1:0]       grant_o
);
    logic [IW-1:0]    cand;
    logic [ABITS-1:0] cand_addr;
    logic [ABITS-1:0] g0_addr;

    always_comb begin
        g0_vld_o  = 1'b0;
        g0_idx_o  = '0;
        g1_vld_o  = 1'b0;
        g1_idx_o  = '0;
        grant_o   = '0;
        cand      = '0;
        cand_addr = '0;
        g0_addr   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand      = IW'((32'(ptr_i) + k) % NREQ);
            cand_addr = addr_i[32'(cand)*ABITS +: ABITS];
            if (valid_i[cand]) begin
                if (!g0_vld_o) begin
                    g0_vld_o = 1'b1;
                    g0_idx_o = cand;
                    g0_addr  = cand_addr;
                end else if (!g1_vld_o &&
                             !((cand_addr == g0_addr) && (we_i[cand] || we_i[g0_idx_o]))) begin
                    g1_vld_o = 1'b1;
                    g1_idx_o = cand;
                end
            end
        end
        if (g0_vld_o) grant_o[g0_idx_o] = 1'b1;
        if (g1_vld_o) grant_o[g1_idx_o] = 1'b1;
    end
endmodule

// File: rtl/gsram_16384x1_arb.sv
// Dual-port arbiter in front of one GSRAM_16384x1: zero-fill sweep after
// reset/clear, then round-robin sharing of both SRAM ports among NREQ requesters.
module gsram_16384x1_arb
    import gsram_16384x1_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned ABITS = ABITS_DEF
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               clr_req,
    output logic               init_done,
    gsram_16384x1_arb_if.slave req_if,
    output logic [ABITS-1:0]   A0,
    output logic [ABITS-1:0]   A1,
    output logic               D0,
    output logic               D1,
    output logic               WE0,
    output logic               WE1,
    output logic               CE0,
    output logic               CE1,
    input  logic               Q0,
    input  logic               Q1
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned KW = ABITS - 1;

    state_e           state_q, state_d;
    logic [KW-1:0]    iaddr_q, iaddr_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [ABITS-1:0] a0_q, a0_d, a1_q, a1_d;
    port_ctl_t        p0_q, p0_d, p1_q, p1_d;
    logic [1:0]       tv_q, tv_d;
    logic [IW-1:0]    ti0_q, ti0_d, ti1_q, ti1_d;
    logic [NREQ-1:0]  rv_q, rv_d, rs_q, rs_d;

    logic [NREQ-1:0]  valid_run;
    logic             g0_vld, g1_vld;
    logic [IW-1:0]    g0_idx, g1_idx, last_idx;
    logic [NREQ-1:0]  grant;

    assign valid_run = (state_q == ST_RUN) ? req_if.req_valid : '0;

    gsram_rr_pick #(
        .NREQ  (NREQ),
        .ABITS (ABITS),
        .IW    (IW)
    ) u_pick (
        .valid_i  (valid_run),
        .we_i     (req_if.req_we),
        .addr_i   (req_if.req_addr),
        .ptr_i    (ptr_q),
        .g0_vld_o (g0_vld),
        .g0_idx_o (g0_idx),
        .g1_vld_o (g1_vld),
        .g1_idx_o (g1_idx),
        .grant_o  (grant)
    );

    assign last_idx = g1_vld ? g1_idx : g0_idx;

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= ST_INIT;
            iaddr_q <= '0;
            ptr_q   <= '0;
            a0_q    <= '0;
            a1_q    <= '0;
            p0_q    <= '0;
            p1_q    <= '0;
            tv_q    <= '0;
            ti0_q   <= '0;
            ti1_q   <= '0;
            rv_q    <= '0;
            rs_q    <= '0;
        end else begin
            state_q <= state_d;
            iaddr_q <= iaddr_d;
            ptr_q   <= ptr_d;
            a0_q    <= a0_d;
            a1_q    <= a1_d;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            tv_q    <= tv_d;
            ti0_q   <= ti0_d;
            ti1_q   <= ti1_d;
            rv_q    <= rv_d;
            rs_q    <= rs_d;
        end
    end

    // Next state: sweep completes on the last even/odd pair; clear restarts it
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT: if (!clr_req && (iaddr_q == '1)) state_d = ST_RUN;
            ST_RUN:  if (clr_req) state_d = ST_INIT;
            default: state_d = ST_INIT;
        endcase
    end

    // Port drive, read tags and pointer update
    always_comb begin
        iaddr_d = iaddr_q;
        ptr_d   = ptr_q;
        a0_d    = '0;
        a1_d    = '0;
        p0_d    = '0;
        p1_d    = '0;
        tv_d    = '0;
        ti0_d   = '0;
        ti1_d   = '0;
        unique case (state_q)
            ST_INIT: begin
                a0_d    = {iaddr_q, 1'b0};
                a1_d    = {iaddr_q, 1'b1};
                p0_d    = '{ce: 1'b1, we: 1'b1, d: 1'b0};
                p1_d    = '{ce: 1'b1, we: 1'b1, d: 1'b0};
                iaddr_d = clr_req ? '0 : iaddr_q + KW'(1);
            end
            ST_RUN: begin
                iaddr_d = '0;
                if (g0_vld) begin
                    a0_d  = req_if.req_addr[32'(g0_idx)*ABITS +: ABITS];
                    p0_d  = '{ce: 1'b1, we: req_if.req_we[g0_idx], d: req_if.req_wdata[g0_idx]};
                    tv_d[0] = !req_if.req_we[g0_idx];
                    ti0_d = g0_idx;
                    ptr_d = IW'((32'(last_idx) + 32'd1) % NREQ);
                end
                if (g1_vld) begin
                    a1_d  = req_if.req_addr[32'(g1_idx)*ABITS +: ABITS];
                    p1_d  = '{ce: 1'b1, we: req_if.req_we[g1_idx], d: req_if.req_wdata[g1_idx]};
                    tv_d[1] = !req_if.req_we[g1_idx];
                    ti1_d = g1_idx;
                end
            end
            default: ;
        endcase
    end

    // Second read stage: tags keep flowing through a clear so in-flight reads complete
    always_comb begin
        rv_d = '0;
        rs_d = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rv_d[i] = (tv_q[0] && (ti0_q == IW'(i))) || (tv_q[1] && (ti1_q == IW'(i)));
            rs_d[i] = tv_q[1] && (ti1_q == IW'(i));
        end
    end

    always_comb begin
        req_if.rsp_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_if.rsp_data[i] = rv_q[i] & (rs_q[i] ? Q1 : Q0);
        end
    end

    assign req_if.req_ready = grant;
    assign req_if.rsp_valid = rv_q;
    assign init_done        = (state_q == ST_RUN);

    assign A0  = a0_q;
    assign A1  = a1_q;
    assign D0  = p0_q.d;
    assign D1  = p1_q.d;
    assign WE0 = p0_q.we;
    assign WE1 = p1_q.we;
    assign CE0 = p0_q.ce;
    assign CE1 = p1_q.ce;
endmodule
